// File: rtl/seg7_scan_capture.sv
// Receive side of the multiplexed 7-segment path: samples segment/digit-select lines,
// debounces each digit, decodes hex glyphs and hands complete frames over valid/ready.
module seg7_scan_capture #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg7_in,
    input  logic [DIGITS-1:0]     dig_sel,
    input  logic                  frame_ready,
    output logic                  frame_valid,
    output logic [4*DIGITS-1:0]   value_out,
    output logic [DIGITS-1:0]     invalid_out,
    output logic                  overrun
);

    localparam int              SW      = DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // Returns {invalid, nibble}; anything outside the 16 hex glyphs is invalid with nibble 0.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h77:   decode = 5'h0A;
            7'h7C:   decode = 5'h0B;
            7'h39:   decode = 5'h0C;
            7'h5E:   decode = 5'h0D;
            7'h79:   decode = 5'h0E;
            7'h71:   decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    logic [SW-1:0]       r_sample;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_done;
    logic [DIGITS-1:0]   r_mask;
    logic [4*DIGITS-1:0] r_slot_val;
    logic [DIGITS-1:0]   r_slot_inv;

    logic [SW-1:0]       w_sample;
    logic                w_change;
    logic [DIGITS-1:0]   w_sel;
    logic                w_onehot;
    logic                w_capture;
    logic                w_mask_full;
    logic [4:0]          w_dec;

    assign w_sample    = {dig_sel, seg7_in};
    // The dwell counter describes how long r_sample has held, so it is updated on the
    // same edge that reloads r_sample by comparing the incoming copy with the held one.
    assign w_change    = (w_sample != r_sample);
    assign w_sel       = r_sample[SW-1:7];
    assign w_onehot    = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
    assign w_capture   = (r_cnt == CNT_MAX) && !r_done && w_onehot;
    assign w_mask_full = &r_mask;
    assign w_dec       = decode(r_sample[6:0]);

    // NOTE: all state below uses non-blocking assignments so every register sees
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_sample <= w_sample;
            if (w_change) begin
                r_cnt  <= '0;
                r_done <= 1'b0;
            end else begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                if (w_capture)        r_done <= 1'b1;
            end
        end
    end

    // NOTE: the slot registers are small and explicitly reset so a partial frame after
    // reset never exposes stale data; wide memories elsewhere would not be reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask     <= '0;
            r_slot_val <= '0;
            r_slot_inv <= '0;
        end else begin
            r_mask <= (w_mask_full ? '0 : r_mask) | (w_capture ? w_sel : '0);
            for (int i = 0; i < DIGITS; i++) begin
                if (w_capture && w_sel[i]) begin
                    r_slot_val[4*i +: 4] <= w_dec[3:0];
                    r_slot_inv[i]        <= w_dec[4];
                end
            end
        end
    end

    // A full mask loads the output if it is empty or being drained this edge; else the frame is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_valid <= 1'b0;
            value_out   <= '0;
            invalid_out <= '0;
            overrun     <= 1'b0;
        end else if (w_mask_full) begin
            if (!frame_valid || frame_ready) begin
                frame_valid <= 1'b1;
                value_out   <= r_slot_val;
                invalid_out <= r_slot_inv;
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Self-checking bench for seg7_scan_capture: directed scenarios plus random scanning,
// compared every cycle against a run-length based reference model.
module tb_seg7_scan_capture;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg7_in = '0;
    logic [3:0]  dig_sel = '0;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [15:0] value_out;
    logic [3:0]  invalid_out;
    logic        overrun;

    always #5 clk = ~clk;

    seg7_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg7_in     (seg7_in),
        .dig_sel     (dig_sel),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .value_out   (value_out),
        .invalid_out (invalid_out),
        .overrun     (overrun)
    );

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a digit is taken once its input has been seen unchanged on STABLE
    // consecutive edges; it lands in its slot one edge later, the frame one edge after that.
    logic [10:0] m_prev;
    int          m_run;
    logic        m_pend;
    logic [10:0] m_pend_x;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_slot_inv;
    logic [3:0]  m_mask;
    logic        m_valid;
    logic [15:0] m_val;
    logic [3:0]  m_inv;
    logic        m_ovr;

    task automatic ref_decode(input logic [6:0] s, output logic [3:0] nib, output logic inv);
        nib = 4'h0;
        inv = 1'b1;
        for (int g = 0; g < 16; g++) begin
            if (glyph[g] == s) begin
                nib = g[3:0];
                inv = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_prev = '0; m_run = 1; m_pend = 1'b0; m_pend_x = '0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
        m_slot_inv = '0; m_mask = '0;
        m_valid = 1'b0; m_val = '0; m_inv = '0; m_ovr = 1'b0;
    endtask

    task automatic model_step();
        logic [10:0] x;
        logic [3:0]  nib;
        logic        inv;
        x = {dig_sel, seg7_in};
        if (m_mask == 4'hF) begin
            if (!m_valid || frame_ready) begin
                m_valid = 1'b1;
                m_val   = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                m_inv   = m_slot_inv;
            end else begin
                m_ovr = 1'b1;
            end
            m_mask = '0;
        end else if (m_valid && frame_ready) begin
            m_valid = 1'b0;
        end
        if (m_pend) begin
            for (int i = 0; i < 4; i++) begin
                if (m_pend_x[7+i]) begin
                    ref_decode(m_pend_x[6:0], nib, inv);
                    m_slot[i]     = nib;
                    m_slot_inv[i] = inv;
                    m_mask[i]     = 1'b1;
                end
            end
            m_pend = 1'b0;
        end
        if (x == m_prev) begin
            if (m_run <= STABLE) m_run++;
        end else begin
            m_run = 1;
        end
        m_prev = x;
        if (m_run == STABLE && $countones(x[10:7]) == 1) begin
            m_pend   = 1'b1;
            m_pend_x = x;
        end
    endtask

    int          ncyc = 0;
    logic        fv_q = 1'b0;
    int          rise_cnt = 0;
    int          rise_edge = 0;
    logic [15:0] rise_val = '0;
    logic [3:0]  rise_inv = '0;
    int          first_edge = 0;

    // One clock: compare outputs of the previous edge, then drive inputs for the next edge.
    task automatic cyc(input logic [3:0] d, input logic [6:0] s, input logic r,
                       input logic rst = 1'b1);
        @(negedge clk);
        ncyc++;
        check("frame_valid", 32'(frame_valid), 32'(m_valid));
        check("value_out",   32'(value_out),   32'(m_val));
        check("invalid_out", 32'(invalid_out), 32'(m_inv));
        check("overrun",     32'(overrun),     32'(m_ovr));
        if (frame_valid && !fv_q) begin
            rise_cnt++;
            rise_edge = ncyc - 1;
            rise_val  = value_out;
            rise_inv  = invalid_out;
        end
        fv_q        = frame_valid;
        rst_n       = rst;
        dig_sel     = d;
        seg7_in     = s;
        frame_ready = r;
        if (!rst) model_reset();
        else      model_step();
    endtask

    task automatic show(input int pos, input logic [6:0] s, input int n, input logic r,
                        input int rdy_at = -1);
        for (int j = 0; j < n; j++) begin
            cyc(4'(1 << pos), s, (j == rdy_at) ? 1'b1 : r);
            if (j == 0) first_edge = ncyc;
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int j = 0; j < n; j++) cyc(4'h0, 7'h00, r);
    endtask

    task automatic frame(input logic [15:0] v, input logic r);
        logic [3:0] nib;
        for (int i = 0; i < 4; i++) begin
            nib = v[4*i +: 4];
            show(i, glyph[nib], 6, r);
        end
    endtask

    task automatic do_reset();
        for (int j = 0; j < 3; j++) cyc(4'($urandom), 7'($urandom), 1'($urandom), 1'b0);
        cyc(4'h0, 7'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int r0;
        int d3;
        model_reset();

        // Reset with random inputs, then a long idle stretch.
        do_reset();
        idle(100, 1'b1);
        check("idle_valid",   32'(frame_valid), 32'd0);
        check("idle_value",   32'(value_out),   32'd0);
        check("idle_overrun", 32'(overrun),     32'd0);
        check("idle_frames",  32'(rise_cnt),    32'd0);

        // Basic frame and latency.
        r0 = rise_cnt;
        show(0, 7'h7D, 6, 1'b1);
        show(1, 7'h6F, 6, 1'b1);
        show(2, 7'h77, 6, 1'b1);
        show(3, 7'h5E, 6, 1'b1);
        d3 = first_edge;
        idle(4, 1'b1);
        check("basic_frames",  32'(rise_cnt - r0),  32'd1);
        check("basic_value",   32'(rise_val),       32'hDA96);
        check("basic_invalid", 32'(rise_inv),       32'd0);
        check("basic_latency", 32'(rise_edge - d3), 32'd5);
        check("basic_drained", 32'(frame_valid),    32'd0);

        // Glitch on digit 0 and a non-one-hot select must not capture.
        r0 = rise_cnt;
        show(0, 7'h06, 2, 1'b1);
        show(0, 7'h5B, 6, 1'b1);
        for (int j = 0; j < 10; j++) cyc(4'b0011, 7'h06, 1'b1);
        show(1, 7'h06, 6, 1'b1);
        show(2, 7'h4F, 6, 1'b1);
        show(3, 7'h66, 6, 1'b1);
        idle(4, 1'b1);
        check("glitch_frames", 32'(rise_cnt - r0), 32'd1);
        check("glitch_value",  32'(rise_val),      32'h4312);

        // Invalid glyph overwritten before completion, then a frame keeping it.
        show(0, 7'h3F, 6, 1'b1);
        show(1, 7'h00, 6, 1'b1);
        show(2, 7'h7F, 6, 1'b1);
        show(1, 7'h4F, 6, 1'b1);
        show(3, 7'h71, 6, 1'b1);
        idle(4, 1'b1);
        check("overwrite_value",   32'(rise_val), 32'hF830);
        check("overwrite_invalid", 32'(rise_inv), 32'd0);
        show(0, 7'h06, 6, 1'b1);
        show(1, 7'h00, 6, 1'b1);
        show(2, 7'h06, 6, 1'b1);
        show(3, 7'h06, 6, 1'b1);
        idle(4, 1'b1);
        check("blank_value",   32'(rise_val), 32'h1101);
        check("blank_invalid", 32'(rise_inv), 32'b0010);

        // Backpressure: second frame dropped, first held.
        frame(16'h1234, 1'b0);
        idle(2, 1'b0);
        check("bp_held_valid", 32'(frame_valid), 32'd1);
        check("bp_held_value", 32'(value_out),   32'h1234);
        frame(16'h5678, 1'b0);
        idle(2, 1'b0);
        check("bp_keep_value", 32'(value_out),   32'h1234);
        check("bp_overrun",    32'(overrun),     32'd1);
        r0 = rise_cnt;
        idle(4, 1'b1);
        check("bp_drained",    32'(frame_valid), 32'd0);
        check("bp_no_reload",  32'(rise_cnt - r0), 32'd0);
        check("bp_sticky",     32'(overrun),     32'd1);

        // Accept and load on the same edge.
        do_reset();
        check("rst_overrun", 32'(overrun), 32'd0);
        frame(16'hABCD, 1'b0);
        idle(2, 1'b0);
        check("sim_first", 32'(value_out), 32'hABCD);
        r0 = rise_cnt;
        show(0, glyph[4'hE], 6, 1'b0);
        show(1, glyph[4'h1], 6, 1'b0);
        show(2, glyph[4'hF], 6, 1'b0);
        show(3, glyph[4'h0], 6, 1'b0, 5);
        cyc(4'h0, 7'h00, 1'b0);
        check("sim_valid",   32'(frame_valid),    32'd1);
        check("sim_value",   32'(value_out),      32'h0F1E);
        check("sim_overrun", 32'(overrun),        32'd0);
        check("sim_no_gap",  32'(rise_cnt - r0),  32'd0);
        idle(3, 1'b1);

        // Reset mid-scan discards the partial frame.
        r0 = rise_cnt;
        show(0, glyph[4'h6], 6, 1'b1);
        show(1, glyph[4'h7], 6, 1'b1);
        do_reset();
        show(2, glyph[4'h8], 6, 1'b1);
        show(3, glyph[4'h9], 6, 1'b1);
        idle(6, 1'b1);
        check("midrst_frames", 32'(rise_cnt - r0), 32'd0);
        frame(16'h9876, 1'b1);
        idle(4, 1'b1);
        check("midrst_full",  32'(rise_cnt - r0), 32'd1);
        check("midrst_value", 32'(rise_val),      32'h9876);

        // Random scanning with random backpressure.
        for (int k = 0; k < 300; k++) begin
            logic [3:0] d;
            logic [6:0] s;
            int         len;
            d   = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            s   = ($urandom_range(0, 5) == 0) ? 7'($urandom) : glyph[$urandom_range(0, 15)];
            len = $urandom_range(1, 7);
            for (int j = 0; j < len; j++) cyc(d, s, ($urandom_range(0, 2) != 0));
        end
        idle(8, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive side of the team's multiplexed 7-segment display path: samples the segment bus and digit-select lines driven by the display logic.
- Recovers the 4-bit hex digit shown on each position and assembles a full multi-digit frame.
- Delivers each frame over a valid/ready interface.
- Used as an on-chip display monitor and as a loopback checker for the segment encoder.

Parameters:
- DIGITS, 4, number of multiplexed digit positions.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (minimum 2).
- CNT_W, 8, width of the dwell counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- seg7_in  input  7  segment pattern, active-high; bit0=a … bit6=g.
- dig_sel  input  DIGITS  digit enable, one-hot, active-high; bit i = position i (i=0 is the least-significant nibble).
- frame_ready  input  1  consumer accepts the frame.
- frame_valid  output  1  frame available.
- value_out  output  4*DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- invalid_out  output  DIGITS  bit i set when digit i's pattern was not a legal hex glyph.
- overrun  output  1  sticky: a completed frame was dropped.

Behaviour:
- Reset: async assert clears everything.
  - All outputs go to 0.
  - Input sample register goes to 0 (dig_sel=0 is non-one-hot, so no spurious capture).
  - Dwell counter, capture-done flag, captured mask and slot registers go to 0.
  - Reset mid-frame discards partial frames.
- Input stage: {dig_sel, seg7_in} is registered once per clk. All decisions use the registered copy.
- Dwell counter:
  - Clears to 0 when the registered sample differs from the previous registered sample.
  - Otherwise it increments, saturating at STABLE_CYCLES-1.
  - The done flag clears on any sample change.
- Capture rule: capture fires on the edge where the counter equals STABLE_CYCLES-1, done=0 and the registered dig_sel is one-hot.
  - The capture writes slot i and sets captured mask bit i and done.
  - Only one capture happens per dwell. A held display never re-captures.
  - Zero or multiple dig_sel bits: no capture, but the counter still runs.
- Decode map (hex, g..a) → nibble:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
  - Any other pattern (including 00 blank) stores nibble 0 and sets the slot's invalid bit. A valid capture clears it.
- Re-capture of a position before the frame completes overwrites that slot (latest wins).
- Frame completion: on the edge after the captured mask becomes all-ones:
  - If the output register is free, or is being accepted in that same cycle (frame_valid & frame_ready), load value_out/invalid_out, assert frame_valid and clear the mask.
  - If the output is occupied and not being accepted: drop the new frame, keep the held frame unchanged, set overrun and clear the mask.
- Output handshake:
  - value_out/invalid_out are stable while frame_valid=1.
  - Transfer occurs on the edge where frame_valid & frame_ready.
  - frame_valid falls on the next cycle unless a new frame loads on that same edge, in which case it stays 1 with the new data.
  - frame_ready while frame_valid=0 has no effect.
- Latency: the final digit's capture occurs STABLE_CYCLES edges after the edge that first registers its pattern. frame_valid rises one edge later, i.e. 5 edges for STABLE_CYCLES=4.
- overrun clears only by reset.

Test Plan:
- Reset/idle: hold rst_n=0 with random inputs, then release with dig_sel=0 → all outputs 0, no frame_valid for 100 cycles.
- Basic frame: DIGITS=4, STABLE_CYCLES=4, frame_ready=1; scan dig_sel 0001/0010/0100/1000 with 7D,6F,77,5E, each held 6 cycles → one frame_valid pulse, value_out=16'hDA96, invalid_out=0, rising 5 edges after digit 3's first registered sample.
- Glitch rejection: digit 0 shows 06 for 2 cycles, then 5B for 6 cycles; dig_sel=0011 held 10 cycles → slot 0=2; no capture on the 06 glitch or on 0011.
- Invalid glyph and overwrite: digit 1 shows 00, later re-shown as 4F before the frame completes → invalid_out[1]=0, nibble 3; a separate frame with 00 on digit 1 → invalid_out=4'b0010, nibble 0.
- Backpressure/overrun: frame_ready=0; complete frame 1234h then frame 5678h → value_out stays 16'h1234, overrun=1; raise frame_ready → one transfer, then frame_valid=0.
- Simultaneous accept and load: frame 2 completes on the same edge frame 1 is accepted → frame_valid stays 1, value updates to frame 2, overrun=0. Assert rst_n=0 mid-scan → mask is cleared and a full new scan is needed.
